// File: rtl/hazard_unit_pkg.sv
// Shared encodings and small decode helpers for the pipeline hazard controller.
package hazard_unit_pkg;

  // Result type of a register-writing instruction
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_ALU  = 2'b01;
  localparam logic [1:0] RES_DM   = 2'b10;
  localparam logic [1:0] RES_PC   = 2'b11;

  // Operand use time
  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Forwarding mux selects
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;
  localparam logic [1:0] FWD_E  = 2'd3;

  // Multiply/divide start codes
  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  localparam int unsigned CNT_W = 4;

  // Cycles until the result of a producer in E is available
  function automatic logic [1:0] tnew_e(input logic [1:0] res);
    logic [1:0] t;
    t = 2'd0;
    unique case (res)
      RES_ALU: t = 2'd1;
      RES_DM:  t = 2'd2;
      default: t = 2'd0;
    endcase
    return t;
  endfunction

  // Only a load is still in flight once it reaches M
  function automatic logic [1:0] tnew_m(input logic [1:0] res);
    return (res == RES_DM) ? 2'd1 : 2'd0;
  endfunction

  // A producer matches when it writes the nonzero source register
  function automatic logic src_match(input logic [4:0] a, input logic [4:0] a3,
                                     input logic [1:0] res);
    return (a != 5'd0) && (a == a3) && (res != RES_NONE);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// HI/LO unit busy counter: loads on mult/div start, otherwise counts down to zero.
module md_busy_counter
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_flush,
  input  logic [1:0] i_start,
  output logic       o_busy
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;

  // Next count: a start (unless flushed) reloads, else decrement while nonzero
  always_comb begin
    w_count_next = r_count;
    if (!i_flush && (i_start == MD_MULT)) begin
      w_count_next = CNT_W'(MULT_CYCLES);
    end else if (!i_flush && (i_start == MD_DIV)) begin
      w_count_next = CNT_W'(DIV_CYCLES);
    end else if (r_count != '0) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Count register, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_busy = (r_count != '0);

endmodule

// File: rtl/hazard_unit.sv
// Stall and forwarding controller for the five-stage pipeline; tracks M/W
// producers itself and combines data hazards with HI/LO busy stalls.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       EXC_flush,
  input  logic [4:0] A1_ID,
  input  logic [4:0] A2_ID,
  input  logic [1:0] Tuse_rs_ID,
  input  logic [1:0] Tuse_rt_ID,
  input  logic       md_use_ID,
  input  logic [1:0] Res_E,
  input  logic [4:0] A1_E,
  input  logic [4:0] A2_E,
  input  logic [4:0] A3_E,
  input  logic [1:0] md_start_E,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       fwd_rt_M,
  output logic [1:0] Res_M,
  output logic [1:0] Res_W,
  output logic [4:0] A3_M,
  output logic [4:0] A3_W,
  output logic       md_busy
);

  logic [1:0] r_res_m, r_res_w;
  logic [4:0] r_a3_m, r_a2_m, r_a3_w;

  logic w_rs_e, w_rs_m, w_rs_w;
  logic w_rt_e, w_rt_m, w_rt_w;
  logic w_e1_m, w_e1_w, w_e2_m, w_e2_w;
  logic w_stall_rs, w_stall_rt, w_stall_md;
  logic w_md_busy;

  // Source/producer matches for D operands (rs, rt) and E operands (A1_E, A2_E)
  always_comb begin
    w_rs_e = src_match(A1_ID, A3_E, Res_E);
    w_rs_m = src_match(A1_ID, r_a3_m, r_res_m);
    w_rs_w = src_match(A1_ID, r_a3_w, r_res_w);
    w_rt_e = src_match(A2_ID, A3_E, Res_E);
    w_rt_m = src_match(A2_ID, r_a3_m, r_res_m);
    w_rt_w = src_match(A2_ID, r_a3_w, r_res_w);
    w_e1_m = src_match(A1_E, r_a3_m, r_res_m);
    w_e1_w = src_match(A1_E, r_a3_w, r_res_w);
    w_e2_m = src_match(A2_E, r_a3_m, r_res_m);
    w_e2_w = src_match(A2_E, r_a3_w, r_res_w);
  end

  // Stall: nearest producer (E before M) not ready by use time, or HI/LO in use
  always_comb begin
    w_stall_rs = 1'b0;
    w_stall_rt = 1'b0;
    if (w_rs_e)      w_stall_rs = (tnew_e(Res_E) > Tuse_rs_ID);
    else if (w_rs_m) w_stall_rs = (tnew_m(r_res_m) > Tuse_rs_ID);
    if (w_rt_e)      w_stall_rt = (tnew_e(Res_E) > Tuse_rt_ID);
    else if (w_rt_m) w_stall_rt = (tnew_m(r_res_m) > Tuse_rt_ID);
    w_stall_md = md_use_ID && (w_md_busy || (md_start_E != MD_NONE));
    stall      = w_stall_rs || w_stall_rt || w_stall_md;
  end

  // Forward selects: nearest producer wins, and only forwards once its value exists
  always_comb begin
    fwd_rs_D = FWD_RF;
    fwd_rt_D = FWD_RF;
    fwd_rs_E = FWD_RF;
    fwd_rt_E = FWD_RF;
    if (w_rs_e)      fwd_rs_D = (tnew_e(Res_E) == 2'd0) ? FWD_E : FWD_RF;
    else if (w_rs_m) fwd_rs_D = (tnew_m(r_res_m) == 2'd0) ? FWD_M : FWD_RF;
    else if (w_rs_w) fwd_rs_D = FWD_W;
    if (w_rt_e)      fwd_rt_D = (tnew_e(Res_E) == 2'd0) ? FWD_E : FWD_RF;
    else if (w_rt_m) fwd_rt_D = (tnew_m(r_res_m) == 2'd0) ? FWD_M : FWD_RF;
    else if (w_rt_w) fwd_rt_D = FWD_W;
    if (w_e1_m)      fwd_rs_E = (tnew_m(r_res_m) == 2'd0) ? FWD_M : FWD_RF;
    else if (w_e1_w) fwd_rs_E = FWD_W;
    if (w_e2_m)      fwd_rt_E = (tnew_m(r_res_m) == 2'd0) ? FWD_M : FWD_RF;
    else if (w_e2_w) fwd_rt_E = FWD_W;
    fwd_rt_M = src_match(r_a2_m, r_a3_w, r_res_w);
  end

  // M/W producer tracking; a flush kills both the excepting and following instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_m <= RES_NONE;
      r_a3_m  <= 5'd0;
      r_a2_m  <= 5'd0;
      r_res_w <= RES_NONE;
      r_a3_w  <= 5'd0;
    end else if (EXC_flush) begin
      r_res_m <= RES_NONE;
      r_a3_m  <= 5'd0;
      r_a2_m  <= 5'd0;
      r_res_w <= RES_NONE;
      r_a3_w  <= 5'd0;
    end else begin
      r_res_m <= Res_E;
      r_a3_m  <= A3_E;
      r_a2_m  <= A2_E;
      r_res_w <= r_res_m;
      r_a3_w  <= r_a3_m;
    end
  end

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .i_flush(EXC_flush),
    .i_start(md_start_E),
    .o_busy (w_md_busy)
  );

  assign md_busy = w_md_busy;
  assign Res_M   = r_res_m;
  assign Res_W   = r_res_w;
  assign A3_M    = r_a3_m;
  assign A3_W    = r_a3_w;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: expectations are queued with each stimulus
// step and drained against the DUT outputs at the following negedge.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       EXC_flush;
  logic [4:0] A1_ID, A2_ID;
  logic [1:0] Tuse_rs_ID, Tuse_rt_ID;
  logic       md_use_ID;
  logic [1:0] Res_E;
  logic [4:0] A1_E, A2_E, A3_E;
  logic [1:0] md_start_E;
  logic       stall;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic       fwd_rt_M;
  logic [1:0] Res_M, Res_W;
  logic [4:0] A3_M, A3_W;
  logic       md_busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef enum int {S_STALL, S_FRSD, S_FRTD, S_FRSE, S_FRTE, S_FRTM,
                    S_RESM, S_RESW, S_A3M, S_A3W, S_BUSY} sig_e;
  typedef struct {
    string      tag;
    sig_e       sig;
    logic [4:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .EXC_flush (EXC_flush),
    .A1_ID     (A1_ID),
    .A2_ID     (A2_ID),
    .Tuse_rs_ID(Tuse_rs_ID),
    .Tuse_rt_ID(Tuse_rt_ID),
    .md_use_ID (md_use_ID),
    .Res_E     (Res_E),
    .A1_E      (A1_E),
    .A2_E      (A2_E),
    .A3_E      (A3_E),
    .md_start_E(md_start_E),
    .stall     (stall),
    .fwd_rs_D  (fwd_rs_D),
    .fwd_rt_D  (fwd_rt_D),
    .fwd_rs_E  (fwd_rs_E),
    .fwd_rt_E  (fwd_rt_E),
    .fwd_rt_M  (fwd_rt_M),
    .Res_M     (Res_M),
    .Res_W     (Res_W),
    .A3_M      (A3_M),
    .A3_W      (A3_W),
    .md_busy   (md_busy)
  );

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [4:0] get_obs(input sig_e s);
    logic [4:0] v;
    v = 5'd0;
    case (s)
      S_STALL: v = 5'(stall);
      S_FRSD:  v = 5'(fwd_rs_D);
      S_FRTD:  v = 5'(fwd_rt_D);
      S_FRSE:  v = 5'(fwd_rs_E);
      S_FRTE:  v = 5'(fwd_rt_E);
      S_FRTM:  v = 5'(fwd_rt_M);
      S_RESM:  v = 5'(Res_M);
      S_RESW:  v = 5'(Res_W);
      S_A3M:   v = A3_M;
      S_A3W:   v = A3_W;
      S_BUSY:  v = 5'(md_busy);
      default: v = 5'd0;
    endcase
    return v;
  endfunction

  task automatic push_exp(input string tag, input sig_e s, input logic [4:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check(e.tag, get_obs(e.sig), e.val);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    drain();
  endtask

  task automatic sample_now();
    #1;
    drain();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    EXC_flush  = 1'b0;
    A1_ID      = 5'd0;
    A2_ID      = 5'd0;
    Tuse_rs_ID = 2'd3;
    Tuse_rt_ID = 2'd3;
    md_use_ID  = 1'b0;
    Res_E      = 2'b00;
    A1_E       = 5'd0;
    A2_E       = 5'd0;
    A3_E       = 5'd0;
    md_start_E = 2'b00;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    tick();
    tick();
    push_exp("rst_res_m", S_RESM, 0);
    push_exp("rst_res_w", S_RESW, 0);
    push_exp("rst_a3_m", S_A3M, 0);
    push_exp("rst_a3_w", S_A3W, 0);
    push_exp("rst_busy", S_BUSY, 0);
    push_exp("rst_stall", S_STALL, 0);
    push_exp("rst_fwd_rs_d", S_FRSD, 0);
    push_exp("rst_fwd_rt_e", S_FRTE, 0);
    push_exp("rst_fwd_rt_m", S_FRTM, 0);
    sample();
    reset = 1'b1;
    tick();

    // Load-use on rs in E
    idle(); Res_E = 2'b10; A3_E = 5'd8; A1_ID = 5'd8; Tuse_rs_ID = 2'd1;
    push_exp("lu_stall", S_STALL, 1);
    sample(); tick();
    idle(); A1_ID = 5'd8; Tuse_rs_ID = 2'd1;
    push_exp("lu_stall_gone", S_STALL, 0);
    push_exp("lu_res_m", S_RESM, 2);
    push_exp("lu_a3_m", S_A3M, 8);
    sample(); tick();
    idle(); A1_E = 5'd8; Res_E = 2'b01; A3_E = 5'd10;
    push_exp("lu_fwd_rs_e", S_FRSE, 2);
    push_exp("lu_res_w", S_RESW, 2);
    push_exp("lu_a3_w", S_A3W, 8);
    sample(); tick();

    // ALU result feeding a branch compare
    idle(); Res_E = 2'b01; A3_E = 5'd9; A2_ID = 5'd9; Tuse_rt_ID = 2'd0;
    push_exp("br_stall", S_STALL, 1);
    push_exp("br_fwd_rt_d0", S_FRTD, 0);
    sample(); tick();
    idle(); A2_ID = 5'd9; Tuse_rt_ID = 2'd0;
    push_exp("br_stall_gone", S_STALL, 0);
    push_exp("br_fwd_rt_d", S_FRTD, 1);
    sample(); tick();

    // jal link value forwarded from E
    idle(); Res_E = 2'b11; A3_E = 5'd31; A1_ID = 5'd31; Tuse_rs_ID = 2'd0;
    push_exp("jal_stall", S_STALL, 0);
    push_exp("jal_fwd_rs_d", S_FRSD, 3);
    sample(); tick();

    // Register zero never stalls or forwards
    idle(); Res_E = 2'b01; A3_E = 5'd0; A1_ID = 5'd0; Tuse_rs_ID = 2'd0;
    push_exp("zero_stall", S_STALL, 0);
    push_exp("zero_fwd_rs_d", S_FRSD, 0);
    sample(); tick();

    // Priority: E over M, then M over W, then M-stage store data from W
    idle(); Res_E = 2'b01; A3_E = 5'd12;
    tick();
    idle(); Res_E = 2'b11; A3_E = 5'd12; A1_ID = 5'd12; Tuse_rs_ID = 2'd0;
    push_exp("prio_e_fwd", S_FRSD, 3);
    push_exp("prio_e_stall", S_STALL, 0);
    sample(); tick();
    idle(); A1_ID = 5'd12; Tuse_rs_ID = 2'd0; A1_E = 5'd12; A2_E = 5'd12;
    push_exp("prio_m_fwd_d", S_FRSD, 1);
    push_exp("prio_m_fwd_rs_e", S_FRSE, 1);
    push_exp("prio_m_fwd_rt_e", S_FRTE, 1);
    push_exp("prio_m_fwd_rt_m0", S_FRTM, 0);
    sample(); tick();
    idle(); A1_ID = 5'd12; Tuse_rs_ID = 2'd0;
    push_exp("w_fwd_rs_d", S_FRSD, 2);
    push_exp("w_fwd_rt_m", S_FRTM, 1);
    sample(); tick();

    // Load in M still too late for a D-stage use
    idle(); Res_E = 2'b10; A3_E = 5'd5;
    tick();
    idle(); A1_ID = 5'd5; Tuse_rs_ID = 2'd0; A2_ID = 5'd5; Tuse_rt_ID = 2'd2;
    push_exp("dm_m_stall", S_STALL, 1);
    push_exp("dm_m_fwd", S_FRSD, 0);
    sample(); tick();
    idle(); A1_ID = 5'd5; Tuse_rs_ID = 2'd0;
    push_exp("dm_w_stall", S_STALL, 0);
    push_exp("dm_w_fwd", S_FRSD, 2);
    sample(); tick();

    // Exception flush clears both tracked stages
    idle(); Res_E = 2'b01; A3_E = 5'd6;
    tick();
    idle(); Res_E = 2'b01; A3_E = 5'd7; EXC_flush = 1'b1;
    push_exp("fl_pre_res_m", S_RESM, 1);
    push_exp("fl_pre_a3_m", S_A3M, 6);
    sample(); tick();
    idle();
    push_exp("fl_res_m", S_RESM, 0);
    push_exp("fl_a3_m", S_A3M, 0);
    push_exp("fl_res_w", S_RESW, 0);
    push_exp("fl_a3_w", S_A3W, 0);
    sample(); tick();

    // Divide: stall for start cycle plus ten busy cycles
    idle(); md_start_E = 2'b10; md_use_ID = 1'b1;
    push_exp("div_start_stall", S_STALL, 1);
    push_exp("div_start_busy", S_BUSY, 0);
    sample(); tick();
    for (int i = 0; i < 10; i++) begin
      idle(); md_use_ID = 1'b1;
      push_exp("div_busy_stall", S_STALL, 1);
      push_exp("div_busy", S_BUSY, 1);
      sample(); tick();
    end
    idle(); md_use_ID = 1'b1;
    push_exp("div_done_stall", S_STALL, 0);
    push_exp("div_done_busy", S_BUSY, 0);
    sample(); tick();

    // A start under flush is ignored
    idle(); md_start_E = 2'b01; EXC_flush = 1'b1;
    tick();
    idle();
    push_exp("fl_md_busy", S_BUSY, 0);
    sample(); tick();

    // Mult: five busy cycles
    idle(); md_start_E = 2'b01;
    tick();
    for (int i = 0; i < 5; i++) begin
      idle();
      push_exp("mult_busy", S_BUSY, 1);
      sample(); tick();
    end
    idle();
    push_exp("mult_done", S_BUSY, 0);
    sample(); tick();

    // Asynchronous reset in the middle of a mult
    idle(); md_start_E = 2'b01;
    tick();
    idle();
    push_exp("mr_busy", S_BUSY, 1);
    sample();
    reset = 1'b0;
    push_exp("mr_reset_busy", S_BUSY, 0);
    sample_now();
    tick();
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Stall and forwarding controller for the five-stage pipeline. It consumes the D-stage hazard tuple (result type Res plus register addresses) and the E-stage tuple held by the ID/EX hazard register. It keeps its own M and W copies of that tuple and runs a multiply/divide busy counter. From these it produces one stall signal and the forwarding-mux selects for D, E and M.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu leaves E
- DIV_CYCLES, 10, busy cycles after a div/divu leaves E

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- EXC_flush  in  1  exception/eret flush; kills the instruction entering M
- A1_ID, A2_ID  in  5  rs/rt addresses of the D-stage instruction
- Tuse_rs_ID, Tuse_rt_ID  in  2  use time: 0 = used in D, 1 = used in E, 2 = used in M, 3 = unused
- md_use_ID  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- Res_E  in  2  E-stage result type
- A1_E, A2_E, A3_E  in  5  E-stage source and destination addresses
- md_start_E  in  2  01 = mult in E, 10 = div in E, 00 = none
- stall  out  1  hold PC and the IF/ID register; clear the E-stage registers
- fwd_rs_D, fwd_rt_D  out  2  D compare/branch operand selects
- fwd_rs_E, fwd_rt_E  out  2  ALU operand selects
- fwd_rt_M  out  1  DM write-data select: 1 = W result
- Res_M, Res_W  out  2  tracked result types
- A3_M, A3_W  out  5  tracked destination addresses
- md_busy  out  1  HI/LO unit busy

## Operation
- Res encoding:
  - 00 NONE (no register write)
  - 01 ALU (ready at the end of E)
  - 10 DM (ready at the end of M)
  - 11 PC (link value, ready in E)
- Tnew per stage. Tuse = 3 never hazards.
  - E: PC→0, ALU→1, DM→2
  - M: DM→1, others→0
  - W: 0
- A producer in stage X matches source A if all hold:
  - A≠0
  - A==A3_X
  - Res_X≠NONE
- Data stall: for rs or rt, the nearest matching producer (E first, then M) has Tnew > Tuse.
- MD stall: md_use_ID && (md_busy || md_start_E≠00).
- stall = data stall OR MD stall.
- Forward selects use the nearest matching producer with Tnew==0:
  - 0 = register file / pipeline value
  - 1 = M result
  - 2 = W result
  - 3 = E PC+8 (D only)
- fwd_rt_M = (A3_W==A2 of the M instruction), nonzero, Res_W≠NONE. A2_M is registered internally from A2_E.
- Tracking pipeline, every cycle:
  - {Res_M, A3_M, A2_M} ← E tuple
  - {Res_W, A3_W} ← {Res_M, A3_M}
- On EXC_flush, both the M and W entries load NONE/0. The excepting instruction and the instruction behind it never write.
- Busy counter (4-bit):
  - md_start_E=01 loads MULT_CYCLES; 10 loads DIV_CYCLES.
  - Otherwise it decrements while nonzero.
  - md_busy = (count≠0).
  - md_start_E is ignored in a cycle with EXC_flush.
  - A running count is not affected by EXC_flush.

## Timing
- stall and all fwd_* outputs are combinational from inputs and current state, with zero-cycle latency.
- Tracking registers and the counter update on posedge clk.
- A producer in E appears in Res_M one cycle later and in Res_W two cycles later.
- A mult entering E at cycle t gives md_busy high for cycles t+1 … t+MULT_CYCLES. stall is already high in cycle t if md_use_ID.
- Reset (reset low, async):
  - Res_M, Res_W = 00
  - A3_M, A3_W = 0
  - count = 0
  - stall = 0 unless inputs alone force it
  - all fwd = 0
- Reset mid-divide clears the count immediately.
- Simultaneous matches in E and M: E takes priority. Matches in M and W: M takes priority.
- Address 0 never stalls and never forwards.

## Structure
- Shared package/header holds:
  - Res codes (RES_NONE/ALU/DM/PC)
  - Tuse codes
  - forward-select codes (FWD_RF/M/W/E)
  - md_start codes
- One sub-module, md_busy_counter (load/decrement counter, md_busy output). Stall and forward logic stays flat in hazard_unit.

## Test plan
- Load-use: Res_E=DM, A3_E=8, A1_ID=8, Tuse_rs_ID=1 → stall=1. Next cycle (Res_M=DM, A3_M=8, E cleared) → stall=0, fwd_rs_E=2 once in W.
- ALU→branch: Res_E=ALU, A3_E=9, A2_ID=9, Tuse_rt_ID=0 → stall=1. Next cycle Res_M=ALU → stall=0, fwd_rt_D=1.
- jal link: Res_E=PC, A3_E=31, A1_ID=31, Tuse=0 → stall=0, fwd_rs_D=3.
- $0 guard: Res_E=ALU, A3_E=0, A1_ID=0, Tuse=0 → stall=0, fwd_rs_D=0.
- Divide: md_start_E=10, then md_use_ID=1 held → stall high for 11 cycles (start cycle + 10), md_busy falls after count 10→0.
- Flush/reset: EXC_flush with Res_E=ALU → next cycle Res_M=00, Res_W=00. Assert reset low mid-mult → md_busy=0 immediately.
